// File: rtl/read_data_pkg.sv
// rtl/read_data_pkg.sv - shared state encoding and pixel-pair field layout for read_data
package read_data_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_HBLANK,
        ST_DATA,
        ST_DONE
    } state_t;

    // Pixel-pair memory word: {R_even, G_even, B_even, R_odd, G_odd, B_odd}
    localparam int PIX_W        = 8;
    localparam int PAIR_W       = 6 * PIX_W;
    localparam int R_EVEN_LSB   = 40;
    localparam int G_EVEN_LSB   = 32;
    localparam int B_EVEN_LSB   = 24;
    localparam int R_ODD_LSB    = 16;
    localparam int G_ODD_LSB    = 8;
    localparam int B_ODD_LSB    = 0;

    // Extract one 8-bit colour channel from a pair word
    function automatic logic [PIX_W-1:0] pair_field(input logic [PAIR_W-1:0] word, input int lsb);
        return word[lsb +: PIX_W];
    endfunction

    // Width helper that never returns zero, so 1-entry ranges still get a 1-bit counter
    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/read_data_addr_gen.sv
// rtl/read_data_addr_gen.sv - row/column counters and bottom-up pixel-pair address
module read_data_addr_gen
    import read_data_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 768,
    parameter int IMAGE_HEIGHT = 512,
    parameter int AW           = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [AW-1:0] addr,
    output logic          last_col,
    output logic          last_row
);

    localparam int HALF = IMAGE_WIDTH / 2;
    localparam int CW   = max1($clog2(HALF));
    localparam int RW   = max1($clog2(IMAGE_HEIGHT));

    localparam logic [CW-1:0] COL_LAST = CW'(HALF - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(HALF);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [RW-1:0] row_inv;

    // Column steps every DATA cycle; row steps when a row completes, wrapping after the last
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign last_col = (col == COL_LAST);
    assign last_row = (row == ROW_LAST);

    // BMP stores the bottom row first, so row 0 of the frame maps to the highest row base
    assign row_inv = ROW_LAST - row;
    assign addr    = AW'(row_inv) * ROW_STEP + AW'(col);

endmodule

// File: rtl/read_data.sv
// rtl/read_data.sv - frame reader: sequences pixel-pair memory reads and presents RGB pairs
module read_data
    import read_data_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 768,
    parameter int IMAGE_HEIGHT = 512,
    parameter int START_DELAY  = 100,
    parameter int H_BLANK      = 160,
    localparam int AW          = max1($clog2(IMAGE_WIDTH * IMAGE_HEIGHT / 2))
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_Read,
    output logic [AW-1:0]     mem_Addr,
    input  logic [PAIR_W-1:0] mem_Data,
    output logic              vertical_Pulse,
    output logic              horizontal_Pulse,
    output logic [PIX_W-1:0]  data_Red_Even,
    output logic [PIX_W-1:0]  data_Green_Even,
    output logic [PIX_W-1:0]  data_Blue_Even,
    output logic [PIX_W-1:0]  data_Red_Odd,
    output logic [PIX_W-1:0]  data_Green_Odd,
    output logic [PIX_W-1:0]  data_Blue_Odd,
    output logic              sig_Read_Done
);

    localparam int DW = 16;
    localparam logic [DW-1:0] SD_LAST = DW'((START_DELAY > 0) ? START_DELAY - 1 : 0);
    localparam logic [DW-1:0] HB_LAST = DW'((H_BLANK > 0) ? H_BLANK - 1 : 0);

    state_t        state;
    logic [DW-1:0] dly_cnt;
    logic          rd_d1;
    logic [AW-1:0] gen_addr;
    logic          last_col;
    logic          last_row;

    read_data_addr_gen #(
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .IMAGE_HEIGHT (IMAGE_HEIGHT),
        .AW           (AW)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == ST_IDLE),
        .advance  (state == ST_DATA),
        .addr     (gen_addr),
        .last_col (last_col),
        .last_row (last_row)
    );

    // Frame sequencer; strobes are registered so mem_Read/mem_Addr trail the DATA state by one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            dly_cnt        <= '0;
            vertical_Pulse <= 1'b0;
            mem_Read       <= 1'b0;
            mem_Addr       <= '0;
            sig_Read_Done  <= 1'b0;
        end else begin
            vertical_Pulse <= 1'b0;
            sig_Read_Done  <= 1'b0;
            mem_Read       <= (state == ST_DATA);
            if (state == ST_DATA) begin
                mem_Addr <= gen_addr;
            end
            case (state)
                ST_IDLE: begin
                    // A start coinciding with the done pulse belongs to the finished frame
                    if (start && !sig_Read_Done) begin
                        vertical_Pulse <= 1'b1;
                        dly_cnt        <= '0;
                        state          <= (START_DELAY > 0) ? ST_START :
                                          (H_BLANK > 0)     ? ST_HBLANK : ST_DATA;
                    end
                end
                ST_START: begin
                    if (dly_cnt == SD_LAST) begin
                        dly_cnt <= '0;
                        state   <= (H_BLANK > 0) ? ST_HBLANK : ST_DATA;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                ST_HBLANK: begin
                    if (dly_cnt == HB_LAST) begin
                        dly_cnt <= '0;
                        state   <= ST_DATA;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (last_col) begin
                        if (last_row) begin
                            state <= ST_DONE;
                        end else if (H_BLANK > 0) begin
                            state <= ST_HBLANK;
                        end
                    end
                end
                ST_DONE: begin
                    // Both pipeline stages drained means the final pair is being presented now
                    if (!mem_Read && !rd_d1) begin
                        sig_Read_Done <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Two-stage read pipeline: capture the memory word one cycle after the read, flag it the next
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_d1            <= 1'b0;
            horizontal_Pulse <= 1'b0;
            data_Red_Even    <= '0;
            data_Green_Even  <= '0;
            data_Blue_Even   <= '0;
            data_Red_Odd     <= '0;
            data_Green_Odd   <= '0;
            data_Blue_Odd    <= '0;
        end else begin
            rd_d1            <= mem_Read;
            horizontal_Pulse <= rd_d1;
            if (rd_d1) begin
                data_Red_Even   <= pair_field(mem_Data, R_EVEN_LSB);
                data_Green_Even <= pair_field(mem_Data, G_EVEN_LSB);
                data_Blue_Even  <= pair_field(mem_Data, B_EVEN_LSB);
                data_Red_Odd    <= pair_field(mem_Data, R_ODD_LSB);
                data_Green_Odd  <= pair_field(mem_Data, G_ODD_LSB);
                data_Blue_Odd   <= pair_field(mem_Data, B_ODD_LSB);
            end
        end
    end

endmodule

// File: tb/tb_read_data.sv
// tb/tb_read_data.sv - self-checking bench for read_data
module tb_read_data;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int RL   = W / 2;
    localparam int NW   = W * H / 2;
    localparam int SD_A = 4;
    localparam int HB_A = 2;
    localparam int SD_B = 0;
    localparam int HB_B = 0;
    localparam int FAR  = 100000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;

    logic        a_rd, a_vp, a_hp, a_done;
    logic [3:0]  a_addr;
    logic [47:0] a_mdata;
    logic [7:0]  a_re, a_ge, a_be, a_ro, a_go, a_bo;

    logic        b_rd, b_vp, b_hp, b_done;
    logic [3:0]  b_addr;
    logic [47:0] b_mdata;
    logic [7:0]  b_re, b_ge, b_be, b_ro, b_go, b_bo;

    logic [47:0] mem [NW];

    logic [3:0]  held_addr [2];
    logic [47:0] held_data [2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    read_data #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .START_DELAY(SD_A), .H_BLANK(HB_A)) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .mem_Read(a_rd), .mem_Addr(a_addr), .mem_Data(a_mdata),
        .vertical_Pulse(a_vp), .horizontal_Pulse(a_hp),
        .data_Red_Even(a_re), .data_Green_Even(a_ge), .data_Blue_Even(a_be),
        .data_Red_Odd(a_ro), .data_Green_Odd(a_go), .data_Blue_Odd(a_bo),
        .sig_Read_Done(a_done)
    );

    read_data #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .START_DELAY(SD_B), .H_BLANK(HB_B)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .mem_Read(b_rd), .mem_Addr(b_addr), .mem_Data(b_mdata),
        .vertical_Pulse(b_vp), .horizontal_Pulse(b_hp),
        .data_Red_Even(b_re), .data_Green_Even(b_ge), .data_Blue_Even(b_be),
        .data_Red_Odd(b_ro), .data_Green_Odd(b_go), .data_Blue_Odd(b_bo),
        .sig_Read_Done(b_done)
    );

    // Synchronous memory: word for the address read in cycle t is on mem_Data in t+1
    always @(posedge clk) begin
        if (a_rd) a_mdata <= mem[a_addr];
        if (b_rd) b_mdata <= mem[b_addr];
    end

    function automatic int frame_len(input int sd, input int hb);
        int klast;
        klast = 1 + sd + (H - 1) * (RL + hb) + hb + RL - 1;
        return klast + 3;
    endfunction

    // Timeline of a frame, k cycles after the vertical pulse
    function automatic void model(input int sd, input int hb, input int k,
                                  output bit vp, output bit rd, output bit done, output int addr);
        int j, period, r, p;
        vp     = (k == 0);
        rd     = 1'b0;
        addr   = 0;
        period = RL + hb;
        j      = k - 1 - sd;
        if (j >= 0) begin
            r = j / period;
            p = j % period;
            if (r < H && p >= hb) begin
                rd   = 1'b1;
                addr = (H - 1 - r) * RL + (p - hb);
            end
        end
        done = (k == frame_len(sd, hb));
    endfunction

    task automatic check_cycle(input int sel, input int k, input string tag);
        bit vp, rd, done, rd2, vp2, done2;
        int addr, addr2, sd, hb;
        logic [55:0] act, exp_v;
        sd = sel ? SD_B : SD_A;
        hb = sel ? HB_B : HB_A;
        model(sd, hb, k, vp, rd, done, addr);
        rd2 = 1'b0;
        addr2 = 0;
        if (k >= 2) model(sd, hb, k - 2, vp2, rd2, done2, addr2);
        if (rd)  held_addr[sel] = 4'(addr);
        if (rd2) held_data[sel] = mem[addr2];
        exp_v = {vp, rd, held_addr[sel], rd2, held_data[sel], done};
        if (sel == 0) act = {a_vp, a_rd, a_addr, a_hp, a_re, a_ge, a_be, a_ro, a_go, a_bo, a_done};
        else          act = {b_vp, b_rd, b_addr, b_hp, b_re, b_ge, b_be, b_ro, b_go, b_bo, b_done};
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s dut%0d k=%0d got {vp,rd,addr,hp,data,done}=%h required %h",
                     tag, sel, k, act, exp_v);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start_a = v;
        else          start_b = v;
    endtask

    task automatic fill_mem(input bit replicated);
        logic [63:0] t;
        for (int i = 0; i < NW; i++) begin
            t = {$urandom, $urandom};
            mem[i] = replicated ? {6{8'(i)}} : t[47:0];
        end
    endtask

    task automatic zero_held();
        for (int s = 0; s < 2; s++) begin
            held_addr[s] = '0;
            held_data[s] = '0;
        end
    endtask

    // Full frame; noise=1 toggles start randomly while the frame is in flight
    task automatic run_frame(input int sel, input string tag, input bit noise);
        int t;
        t = frame_len(sel ? SD_B : SD_A, sel ? HB_B : HB_A);
        @(posedge clk); #1 set_start(sel, 1'b1);
        @(posedge clk); #1 set_start(sel, 1'b0);
        for (int k = 0; k <= t + 3; k++) begin
            @(negedge clk);
            check_cycle(sel, k, tag);
            if (noise && k < t - 1) set_start(sel, 1'($urandom_range(0, 1)));
            else if (k == t)        set_start(sel, 1'b1);
            else                    set_start(sel, 1'b0);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        zero_held();
        repeat (2) @(posedge clk);
        #1;
        check_cycle(0, FAR, "reset_a");
        check_cycle(1, FAR, "reset_b");
        @(negedge clk) reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_cycle(0, FAR, "idle_a");
            check_cycle(1, FAR, "idle_b");
        end
    endtask

    task automatic test_replicated_frame();
        fill_mem(1'b1);
        run_frame(0, "repl_frame", 1'b0);
    endtask

    task automatic test_random_frame();
        fill_mem(1'b0);
        run_frame(0, "rand_frame", 1'b1);
    endtask

    task automatic test_back_to_back();
        int t, per, g_end;
        fill_mem(1'b0);
        t     = frame_len(SD_A, HB_A);
        per   = t + 2;
        g_end = 2 * per + 4;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk);
        for (int g = 0; g <= g_end; g++) begin
            @(negedge clk);
            if (g / per < 2) check_cycle(0, g % per, "b2b");
            else             check_cycle(0, FAR, "b2b_tail");
            if (g == per + t) start_a = 1'b0;
        end
    endtask

    task automatic test_mid_reset();
        fill_mem(1'b0);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            check_cycle(0, k, "pre_reset");
        end
        #1 reset = 1'b1;
        zero_held();
        #1 check_cycle(0, FAR, "mid_reset");
        repeat (2) @(posedge clk);
        #1 check_cycle(0, FAR, "mid_reset_hold");
        @(negedge clk) reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check_cycle(0, FAR, "post_reset_idle");
        end
        run_frame(0, "post_reset_frame", 1'b0);
    endtask

    task automatic test_zero_delay();
        fill_mem(1'b0);
        run_frame(1, "zero_delay", 1'b0);
    endtask

    initial begin
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        zero_held();
        test_reset();
        test_replicated_frame();
        test_random_frame();
        test_back_to_back();
        test_mid_reset();
        test_zero_delay();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
